// File: rtl/uart_rx_if.sv
// Serial receiver bus: sampled line in, frame result (valid/err/data) out.
// The slave modport is the receiver, the master modport is the line driver/consumer.
interface uart_rx_if #(
   parameter int unsigned DATA_BITS = 2
);
   logic                 signal;
   logic                 valid;
   logic [DATA_BITS-1:0] data;
   logic                 err;

   modport master (output signal, input valid, input data, input err);
   modport slave  (input signal, output valid, output data, output err);
endinterface

// File: rtl/uart_rx.sv
// One-bit-per-cycle serial frame receiver: start(1), DATA_BITS data (LSB first), stop(1).
// Optional even-parity bit between data and stop when UART_PARITY_EN is defined.
module uart_rx #(
   parameter int unsigned DATA_BITS = 2
) (
   input  logic       clk,
   input  logic       reset,
   uart_rx_if.slave   rx
);

   localparam int unsigned CW = $clog2(DATA_BITS + 1);

`ifdef UART_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic                 par_ok;

`ifdef UART_PARITY_EN
   logic par_ok_q, par_ok_d;
   assign par_ok = par_ok_q;
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
`ifdef UART_PARITY_EN
      par_ok_d = par_ok_q;
`endif
      case (state_q)
         IDLE: begin
            if (rx.signal) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            // Explicit decode keeps the index within the shift register width.
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
               if (cnt_q == CW'(i)) shift_d[i] = rx.signal;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            par_ok_d = ~(rx.signal ^ (^shift_q));
            state_d  = STOP;
         end
`endif
         STOP: begin
            if (rx.signal && par_ok) begin
               valid_d = 1'b1;
               data_d  = shift_q;
            end else begin
               err_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
`ifdef UART_PARITY_EN
         par_ok_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
`ifdef UART_PARITY_EN
         par_ok_q <= par_ok_d;
`endif
      end
   end

   assign rx.valid = valid_q;
   assign rx.err   = err_q;
   assign rx.data  = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (DATA_BITS=2): per-cycle vector table plus frame sequences.
// Expected values follow LSB-first data order; parity vectors apply when UART_PARITY_EN is defined.
module tb_uart_rx;

   localparam int unsigned DB = 2;

   typedef struct {
      logic          rst_n;
      logic          sig;
      logic          ev;
      logic          ee;
      logic [DB-1:0] ed;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   applied = 0;
   int   miscompares = 0;
   logic [DB-1:0] model_data = '0;
   vec_t tbl[$];

   uart_rx_if #(.DATA_BITS(DB)) bus ();

   uart_rx #(.DATA_BITS(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (bus)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic s, input logic v, input logic e,
                               input logic [DB-1:0] d);
      vec_t x;
      x.rst_n = r; x.sig = s; x.ev = v; x.ee = e; x.ed = d;
      tbl.push_back(x);
   endfunction

   task automatic step(input string name, input logic r, input logic s, input logic ev,
                       input logic ee, input logic [DB-1:0] ed);
      @(negedge clk);
      reset      = r;
      bus.signal = s;
      @(posedge clk);
      #1;
      applied++;
      if (bus.valid !== ev || bus.err !== ee || bus.data !== ed) begin
         miscompares++;
         $display("FAIL %s: got valid=%b err=%b data=%b, expected valid=%b err=%b data=%b",
                  name, bus.valid, bus.err, bus.data, ev, ee, ed);
      end
   endtask

   // Full frame with bench-side model of the data register.
   task automatic frame(input string name, input logic [DB-1:0] d, input logic stop,
                        input logic par_flip);
      logic ok;
      step({name, "_start"}, 1'b1, 1'b1, 1'b0, 1'b0, model_data);
      for (int i = 0; i < DB; i++) step({name, "_data"}, 1'b1, d[i], 1'b0, 1'b0, model_data);
`ifdef UART_PARITY_EN
      step({name, "_par"}, 1'b1, (^d) ^ par_flip, 1'b0, 1'b0, model_data);
      ok = stop && !par_flip;
`else
      ok = stop;
`endif
      if (ok) model_data = d;
      step({name, "_stop"}, 1'b1, stop, ok, !ok, model_data);
   endtask

   initial begin
      bus.signal = 1'b0;

      // Reset held two cycles
      add(0,0,0,0,2'b00); add(0,0,0,0,2'b00);
`ifdef UART_PARITY_EN
      add(1,1,0,0,2'b00); add(1,1,0,0,2'b00); add(1,0,0,0,2'b00); add(1,1,0,0,2'b00); add(1,1,1,0,2'b01);
      add(1,1,0,0,2'b01); add(1,1,0,0,2'b01); add(1,0,0,0,2'b01); add(1,0,0,0,2'b01); add(1,1,0,1,2'b01);
      add(1,1,0,0,2'b01); add(1,0,0,0,2'b01); add(1,1,0,0,2'b01); add(1,1,0,0,2'b01); add(1,0,0,1,2'b01);
      add(1,1,0,0,2'b01); add(1,1,0,0,2'b01); add(1,1,0,0,2'b01); add(1,0,0,0,2'b01); add(1,1,1,0,2'b11);
      add(1,0,0,0,2'b11);
      add(1,1,0,0,2'b11); add(1,1,0,0,2'b11);
      add(0,0,0,0,2'b00);
      add(1,0,0,0,2'b00);
`else
      // 1,0,0,1 -> valid, data 00
      add(1,1,0,0,2'b00); add(1,0,0,0,2'b00); add(1,0,0,0,2'b00); add(1,1,1,0,2'b00);
      // back-to-back 1,1,0,1 | 1,0,1,1 -> data 01 then 10
      add(1,1,0,0,2'b00); add(1,1,0,0,2'b00); add(1,0,0,0,2'b00); add(1,1,1,0,2'b01);
      add(1,1,0,0,2'b01); add(1,0,0,0,2'b01); add(1,1,0,0,2'b01); add(1,1,1,0,2'b10);
      add(1,0,0,0,2'b10);
      // two framing errors, data held
      add(1,1,0,0,2'b10); add(1,0,0,0,2'b10); add(1,1,0,0,2'b10); add(1,0,0,1,2'b10);
      add(1,1,0,0,2'b10); add(1,0,0,0,2'b10); add(1,1,0,0,2'b10); add(1,0,0,1,2'b10);
      // 1,0,0,1,0,0,0,1,1,1,1 -> valid 00 at bit 4, valid 11 at bit 11
      add(1,1,0,0,2'b10); add(1,0,0,0,2'b10); add(1,0,0,0,2'b10); add(1,1,1,0,2'b00);
      add(1,0,0,0,2'b00); add(1,0,0,0,2'b00); add(1,0,0,0,2'b00);
      add(1,1,0,0,2'b00); add(1,1,0,0,2'b00); add(1,1,0,0,2'b00); add(1,1,1,0,2'b11);
      add(1,0,0,0,2'b11);
      // reset mid-frame after 1,1, then 1,0,0,1
      add(1,1,0,0,2'b11); add(1,1,0,0,2'b11);
      add(0,0,0,0,2'b00);
      add(1,0,0,0,2'b00);
      add(1,1,0,0,2'b00); add(1,0,0,0,2'b00); add(1,0,0,0,2'b00); add(1,1,1,0,2'b00);
      add(1,0,0,0,2'b00);
`endif

      foreach (tbl[i]) begin
         step($sformatf("tbl[%0d]", i), tbl[i].rst_n, tbl[i].sig, tbl[i].ev, tbl[i].ee, tbl[i].ed);
      end

      // Reset landing on the stop-bit edge suppresses the pulse
      model_data = '0;
      step("rs_start", 1'b1, 1'b1, 1'b0, 1'b0, model_data);
      step("rs_d0", 1'b1, 1'b1, 1'b0, 1'b0, model_data);
      step("rs_d1", 1'b1, 1'b1, 1'b0, 1'b0, model_data);
`ifdef UART_PARITY_EN
      step("rs_par", 1'b1, 1'b0, 1'b0, 1'b0, model_data);
`endif
      step("rs_stop_reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      step("rs_after", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

      // Back-to-back frames over every data value, then error cases
      for (int v = 0; v < 4; v++) frame($sformatf("b2b%0d", v), DB'(v), 1'b1, 1'b0);
      frame("framing_err", 2'b01, 1'b0, 1'b0);
`ifdef UART_PARITY_EN
      frame("parity_err", 2'b10, 1'b1, 1'b1);
`endif
      frame("final", 2'b10, 1'b1, 1'b0);
      step("idle_tail", 1'b1, 1'b0, 1'b0, 1'b0, model_data);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
